// File: rtl/read_cycle.sv
// read_cycle: timed LCD read strobe sequencer capturing one data byte per request
module read_cycle #(
  parameter int T_AS = 1,
  parameter int T_PW = 3,
  parameter int T_H  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_enable,
  input  logic       reg_sel,
  input  logic [7:0] data_in,
  output logic       e_out,
  output logic       rs_out,
  output logic       rw_out,
  output logic       bus_rel,
  output logic       rd_finish,
  output logic [7:0] rd_data,
  output logic       busy_flag
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] EHIGH = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  logic [2:0] state, state_nx;
  logic [3:0] cnt, cnt_nx, phase_end;
  logic       timed, last, accept, capture;
  // phase bookkeeping: the timed phases run consecutively, so a finished phase steps to the next code
  always_comb begin
    timed     = state == SETUP || state == EHIGH || state == HOLD;
    phase_end = state == SETUP ? 4'(T_AS - 1) : state == EHIGH ? 4'(T_PW - 1) : 4'(T_H - 1);
    last      = timed && cnt == phase_end;
    accept    = state == IDLE && rd_enable;
    capture   = state == EHIGH && last;
    state_nx  = accept ? SETUP : last ? state + 3'd1 : state == DONE ? IDLE : state;
    cnt_nx    = timed && !last ? cnt + 4'd1 : 4'd0;
  end
  // sequencer state plus the RS latch and the byte/busy capture taken while E is still high
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rs_out    <= 1'b0;
      rd_data   <= 8'h00;
      busy_flag <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) rs_out <= reg_sel;
      if (capture) rd_data <= data_in;
      if (capture && !rs_out) busy_flag <= data_in[7];
    end
  assign e_out     = state == EHIGH;
  assign rw_out    = timed;
  assign bus_rel   = timed;
  assign rd_finish = state == DONE;
endmodule

// File: tb/tb_read_cycle.sv
// tb_read_cycle: directed and random checks of read_cycle against a per-request timeline model
module tb_read_cycle;
  localparam int AS1 = 1, PW1 = 3, H1 = 1;
  localparam int AS2 = 2, PW2 = 5, H2 = 3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rd_enable = 1'b0;
  logic reg_sel = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic e1, rs1, rw1, br1, fin1, bf1;
  logic e2, rs2, rw2, br2, fin2, bf2;
  logic [7:0] rd1, rd2;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic [4:0] k;
    logic       rs;
    logic [7:0] rd;
    logic       bf;
  } mdl_t;
  mdl_t m1 = '0;
  mdl_t m2 = '0;

  always #5 clk = ~clk;

  read_cycle dut1 (
    .clk(clk), .rst(rst), .rd_enable(rd_enable), .reg_sel(reg_sel), .data_in(data_in),
    .e_out(e1), .rs_out(rs1), .rw_out(rw1), .bus_rel(br1), .rd_finish(fin1),
    .rd_data(rd1), .busy_flag(bf1)
  );

  read_cycle #(.T_AS(AS2), .T_PW(PW2), .T_H(H2)) dut2 (
    .clk(clk), .rst(rst), .rd_enable(rd_enable), .reg_sel(reg_sel), .data_in(data_in),
    .e_out(e2), .rs_out(rs2), .rw_out(rw2), .bus_rel(br2), .rd_finish(fin2),
    .rd_data(rd2), .busy_flag(bf2)
  );

  // k = cycles since the accepting edge (0 = idle); phases are consecutive windows of k
  function automatic mdl_t adv(mdl_t s, int as, int pw, int h, logic en, logic sel, logic [7:0] din);
    mdl_t r = s;
    if (s.k == 5'd0) begin
      if (en) begin
        r.k  = 5'd1;
        r.rs = sel;
      end
    end else r.k = (int'(s.k) == as + pw + h + 1) ? 5'd0 : s.k + 5'd1;
    if (int'(s.k) == as + pw) begin
      r.rd = din;
      if (!s.rs) r.bf = din[7];
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst)
    if (!rst) begin
      m1 <= '0;
      m2 <= '0;
    end else begin
      m1 <= adv(m1, AS1, PW1, H1, rd_enable, reg_sel, data_in);
      m2 <= adv(m2, AS2, PW2, H2, rd_enable, reg_sel, data_in);
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp(input string n, input mdl_t s, input int as, input int pw, input int h,
                     input logic e, input logic rw, input logic br, input logic fin,
                     input logic rs, input logic [7:0] rd, input logic bf);
    int k = int'(s.k);
    chk({n, "_e"}, e, k > as && k <= as + pw);
    chk({n, "_rw"}, rw, k >= 1 && k <= as + pw + h);
    chk({n, "_bus"}, br, k >= 1 && k <= as + pw + h);
    chk({n, "_fin"}, fin, k == as + pw + h + 1);
    chk({n, "_rs"}, rs, s.rs);
    chk({n, "_rd"}, rd, s.rd);
    chk({n, "_bf"}, bf, s.bf);
  endtask

  task automatic tick(input logic en, input logic sel, input logic [7:0] din);
    @(negedge clk);
    cmp("m1", m1, AS1, PW1, H1, e1, rw1, br1, fin1, rs1, rd1, bf1);
    cmp("m2", m2, AS2, PW2, H2, e2, rw2, br2, fin2, rs2, rd2, bf2);
    rd_enable = en;
    reg_sel   = sel;
    data_in   = din;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_e", e1, 1'b0);
    chk("rst_rw", rw1, 1'b0);
    chk("rst_bus", br1, 1'b0);
    chk("rst_fin", fin1, 1'b0);
    chk("rst_rs", rs1, 1'b0);
    chk("rst_rd", rd1, 8'h00);
    chk("rst_bf", bf1, 1'b0);
    chk("rst_e2", e2, 1'b0);
    rst = 1'b1;
    rd_enable = 1'b1;
    data_in = 8'h80;
    for (int j = 1; j <= 12; j++) begin
      tick(1'b0, 1'b0, 8'h80);
      chk("busy_e", e1, j >= 2 && j <= 4);
      chk("busy_rw", rw1, j >= 1 && j <= 5);
      chk("busy_fin", fin1, j == 6);
      chk("slow_e", e2, j >= 3 && j <= 7);
      chk("slow_rw", rw2, j >= 1 && j <= 10);
      chk("slow_fin", fin2, j == 11);
      if (j == 6) begin
        chk("busy_rd", rd1, 8'h80);
        chk("busy_bf", bf1, 1'b1);
      end
    end
    tick(1'b1, 1'b1, 8'h41);
    for (int j = 1; j <= 12; j++) begin
      tick(1'b0, 1'b0, 8'h41);
      if (j == 6) begin
        chk("data_rd", rd1, 8'h41);
        chk("data_rs", rs1, 1'b1);
        chk("data_bf", bf1, 1'b1);
      end
    end
    for (int t = 0; t < 2; t++) begin
      tick(1'b1, 1'b0, 8'h12);
      for (int j = 1; j <= 12; j++) begin
        tick(1'b0, 1'b0, (j >= 5 - t) ? 8'h34 : 8'h12);
        if (j == 6) begin
          chk(t == 0 ? "edge_late_rd" : "edge_early_rd", rd1, t == 0 ? 8'h12 : 8'h34);
          chk("edge_bf", bf1, 1'b0);
        end
      end
    end
    tick(1'b1, 1'b0, 8'h80);
    for (int j = 1; j <= 28; j++) begin
      tick(1'b1, 1'b0, 8'h80);
      chk("b2b_fin", fin1, j % 7 == 6);
      chk("b2b_e", e1, j % 7 >= 2 && j % 7 <= 4);
      chk("b2b_idle", rw1 | fin1, 1'b0 | (j % 7 != 0));
    end
    for (int j = 0; j < 12; j++) tick(1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h80);
    tick(1'b0, 1'b0, 8'h80);
    tick(1'b0, 1'b0, 8'h80);
    tick(1'b0, 1'b0, 8'h80);
    chk("abort_pre_e", e1, 1'b1);
    rst = 1'b0;
    #1;
    chk("abort_e", e1, 1'b0);
    chk("abort_rw", rw1, 1'b0);
    chk("abort_bus", br1, 1'b0);
    chk("abort_rd", rd1, 8'h00);
    chk("abort_e2", e2, 1'b0);
    tick(1'b0, 1'b0, 8'h80);
    rst = 1'b1;
    rd_enable = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      tick(1'b0, 1'b0, 8'h80);
      chk("rerun_fin", fin1, j == 6);
      chk("rerun_rd", rd1, j >= 5 ? 8'h80 : 8'h00);
    end
    for (int j = 0; j < 400; j++) begin
      tick($urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom));
      rst = $urandom_range(0, 59) != 0;
    end
    rst = 1'b1;
    for (int j = 0; j < 14; j++) tick(1'b0, 1'b0, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
